deser_event_merger: RTL and testbench

//   Schedules readout of the two module decoder channels (TBM A, TBM B) onto one 16-bit output stream.

---
 rtl/deser_pkg.sv | 20 ++
 rtl/merger_fifo.sv | 42 ++++
 rtl/deser_event_merger.sv | 119 +++++++++++
 tb/tb_deser_event_merger.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// Shared constants and FSM encoding for the two-channel TBM event merger.
package deser_pkg;

  localparam logic [2:0]  MODE_TBM_HDR  = 3'b101;
  localparam logic [2:0]  MODE_TBM_TRL2 = 3'b110;
  localparam logic [15:0] TMO_WORD      = 16'hDFEE;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR_A = 3'd1,
    ST_DAT_A = 3'd2,
    ST_HDR_B = 3'd3,
    ST_DAT_B = 3'd4
  } state_t;

  function automatic logic [2:0] word_mode(input logic [15:0] w);
    return w[15:13];
  endfunction

endpackage

// File: rtl/merger_fifo.sv
// Per-channel synchronous FIFO with first-word fall-through output.
module merger_fifo #(
  parameter int AW = 4
) (
  input  logic        clk80,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        empty,
  output logic        full
);

  logic [15:0] mem [0:(1<<AW)-1];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk80) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk80) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/deser_event_merger.sv
// Merges TBM A and TBM B decoder streams into one word stream, whole events A then B.
module deser_event_merger
  import deser_pkg::*;
#(
  parameter int AW      = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk80,
  input  logic        reset,
  input  logic [1:0]  enable,
  input  logic        a_write,
  input  logic [15:0] a_data,
  input  logic        b_write,
  input  logic [15:0] b_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        busy,
  output logic [1:0]  ovf,
  output logic [1:0]  sync_err,
  output logic [1:0]  tmo
);

  localparam logic [9:0] TMO_LIM = 10'(TIMEOUT);

  state_t      state;
  state_t      after_close;
  logic        b_en;
  logic [9:0]  tmo_cnt;
  logic [15:0] a_dout, b_dout, cur_word, fwd_word;
  logic        a_empty, a_full, b_empty, b_full;
  logic        sel_b, in_hdr, in_dat, active, cur_empty, slot_free;
  logic        pop_cur, a_pop, b_pop, is_hdr, is_trl;
  logic        timed_out, inject, hdr_tmo, fwd, close;

  merger_fifo #(.AW(AW)) u_fifo_a (
    .clk80(clk80), .reset(reset), .push(a_write), .pop(a_pop), .din(a_data),
    .dout(a_dout), .empty(a_empty), .full(a_full)
  );

  merger_fifo #(.AW(AW)) u_fifo_b (
    .clk80(clk80), .reset(reset), .push(b_write), .pop(b_pop), .din(b_data),
    .dout(b_dout), .empty(b_empty), .full(b_full)
  );

  assign sel_b     = (state == ST_HDR_B) || (state == ST_DAT_B);
  assign in_hdr    = (state == ST_HDR_A) || (state == ST_HDR_B);
  assign in_dat    = (state == ST_DAT_A) || (state == ST_DAT_B);
  assign active    = in_hdr || in_dat;
  assign cur_word  = sel_b ? b_dout : a_dout;
  assign cur_empty = sel_b ? b_empty : a_empty;
  assign slot_free = !out_valid || out_ready;
  assign pop_cur   = active && !cur_empty && slot_free;
  assign a_pop     = pop_cur && !sel_b;
  assign b_pop     = pop_cur && sel_b;
  assign is_hdr    = (word_mode(cur_word) == MODE_TBM_HDR);
  assign is_trl    = (word_mode(cur_word) == MODE_TBM_TRL2);

  // A stalled channel is closed after TIMEOUT idle cycles; only a mid-event stall emits a trailer.
  assign timed_out   = active && cur_empty && (tmo_cnt >= TMO_LIM);
  assign inject      = in_dat && timed_out && slot_free;
  assign hdr_tmo     = in_hdr && timed_out;
  assign fwd         = (pop_cur && (in_dat || is_hdr)) || inject;
  assign fwd_word    = inject ? TMO_WORD : cur_word;
  assign close       = (pop_cur && in_dat && is_trl) || inject || hdr_tmo;
  assign after_close = (!sel_b && b_en) ? ST_HDR_B : ST_IDLE;

  always_ff @(posedge clk80) begin
    if (reset) begin
      state     <= ST_IDLE;
      b_en      <= 1'b0;
      busy      <= 1'b0;
      tmo_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      ovf       <= '0;
      sync_err  <= '0;
      tmo       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable != 2'b00) begin
            b_en  <= enable[1];
            state <= enable[0] ? ST_HDR_A : ST_HDR_B;
            busy  <= 1'b1;
          end
        end
        ST_HDR_A, ST_HDR_B: begin
          if (pop_cur && is_hdr) begin
            state <= sel_b ? ST_DAT_B : ST_DAT_A;
          end else if (hdr_tmo) begin
            state <= after_close;
            busy  <= (after_close != ST_IDLE);
          end
        end
        default: begin
          if (close) begin
            state <= after_close;
            busy  <= (after_close != ST_IDLE);
          end
        end
      endcase

      if (!active || pop_cur || close) tmo_cnt <= '0;
      else if (cur_empty && tmo_cnt != 10'h3FF) tmo_cnt <= tmo_cnt + 10'd1;

      // Output register: reload only when the downstream slot is free, otherwise hold.
      if (slot_free) begin
        out_valid <= fwd;
        if (fwd) out_data <= fwd_word;
      end

      ovf <= ovf | {b_write && b_full && !b_pop, a_write && a_full && !a_pop};
      if (pop_cur && in_hdr && !is_hdr) sync_err[sel_b] <= 1'b1;
      if (inject || hdr_tmo) tmo[sel_b] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_deser_event_merger.sv
// Scoreboard bench for deser_event_merger: event-level reference model, randomized traffic and backpressure.
module tb_deser_event_merger;

  logic        clk80 = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  enable = 2'b00;
  logic        a_write = 1'b0;
  logic [15:0] a_data = 16'h0;
  logic        b_write = 1'b0;
  logic [15:0] b_data = 16'h0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] out_data;
  logic        busy;
  logic [1:0]  ovf, sync_err, tmo;

  int          checks = 0;
  int          errors = 0;
  int          rdy_mode = 1;
  logic [15:0] expq[$];
  logic        stalled = 1'b0;
  logic [15:0] held = 16'h0;
  logic [15:0] exp_w;

  deser_event_merger #(.AW(4), .TIMEOUT(1023)) dut (
    .clk80(clk80), .reset(reset), .enable(enable),
    .a_write(a_write), .a_data(a_data), .b_write(b_write), .b_data(b_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .ovf(ovf), .sync_err(sync_err), .tmo(tmo)
  );

  always #5 clk80 = ~clk80;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every accepted word against the scoreboard; check stability under backpressure.
  always @(negedge clk80) begin
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(held));
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h with nothing expected", out_data);
        end else begin
          exp_w = expq.pop_front();
          chk("out_word", 32'(out_data), 32'(exp_w));
        end
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
    end
  end

  initial begin
    forever begin
      @(posedge clk80);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'($urandom_range(0, 1));
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk80);
      #1;
    end
  endtask

  task automatic wr(input bit ch, input logic [15:0] w);
    if (ch) begin b_write = 1'b1; b_data = w; end
    else    begin a_write = 1'b1; a_data = w; end
    tick(1);
    if (ch) b_write = 1'b0;
    else    a_write = 1'b0;
  endtask

  task automatic wr_stream(input bit ch, input logic [15:0] ws[$], input int maxgap);
    foreach (ws[i]) begin
      tick($urandom_range(0, maxgap));
      wr(ch, ws[i]);
    end
  endtask

  task automatic start(input logic [1:0] m);
    enable = m;
    tick(1);
    enable = 2'b00;
  endtask

  // Reference: words before the first header are dropped; header through first trailer are emitted.
  task automatic expect_event(input logic [15:0] ws[$]);
    bit started = 1'b0;
    bit done    = 1'b0;
    foreach (ws[i]) begin
      if (!done) begin
        if (!started) begin
          if (ws[i][15:13] == 3'b101) begin
            started = 1'b1;
            expq.push_back(ws[i]);
          end
        end else begin
          expq.push_back(ws[i]);
          if (ws[i][15:13] == 3'b110) done = 1'b1;
        end
      end
    end
  endtask

  function automatic logic [15:0] rw(input logic [2:0] mode);
    logic [15:0] w;
    w = 16'($urandom);
    w[15:13] = mode;
    return w;
  endfunction

  task automatic gen_event(output logic [15:0] ws[$], input int ngarb);
    logic [2:0] m;
    int nmid;
    ws = {};
    for (int i = 0; i < ngarb; i++) begin
      do m = 3'($urandom); while (m == 3'b101);
      ws.push_back(rw(m));
    end
    ws.push_back(rw(3'b101));
    nmid = $urandom_range(0, 6);
    for (int i = 0; i < nmid; i++) begin
      do m = 3'($urandom); while (m == 3'b110);
      ws.push_back(rw(m));
    end
    ws.push_back(rw(3'b110));
  endtask

  task automatic wait_done(input string name, input int budget, input bit need_idle);
    int n = 0;
    while ((expq.size() != 0 || (need_idle && (busy || out_valid))) && n < budget) begin
      @(negedge clk80);
      #1;
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s: timed out with %0d words outstanding, busy=%0b", name, expq.size(), busy);
      expq.delete();
    end
  endtask

  initial begin
    logic [15:0] wa[$];
    logic [15:0] wb[$];
    logic [1:0]  m;

    // Reset state
    repeat (3) @(posedge clk80);
    @(negedge clk80);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flags", 32'({ovf, sync_err, tmo}), 32'd0);
    reset = 1'b0;
    tick(2);

    // Two-cycle latency from push to out_valid
    rdy_mode = 1;
    start(2'b01);
    expq.push_back(16'hA055);
    expq.push_back(16'hC056);
    wr(1'b0, 16'hA055);
    @(negedge clk80);
    chk("lat_n1_valid", 32'(out_valid), 32'd0);
    tick(1);
    @(negedge clk80);
    chk("lat_n2_valid", 32'(out_valid), 32'd1);
    chk("lat_n2_data", 32'(out_data), 32'hA055);
    tick(1);
    wr(1'b0, 16'hC056);
    wait_done("lat", 200, 1'b1);

    // A event then B event
    wa = {16'hA001, 16'h0002, 16'h2003, 16'hC004};
    wb = {16'hA101, 16'h4102, 16'hC103};
    expect_event(wa);
    expect_event(wb);
    start(2'b11);
    fork
      wr_stream(1'b0, wa, 0);
      wr_stream(1'b1, wb, 0);
    join
    wait_done("t1", 200, 1'b1);

    // B written before A; A still first
    wa = {16'hA011, 16'h1012, 16'hC013};
    wb = {16'hA111, 16'h3112, 16'h7113, 16'hC114};
    expect_event(wa);
    expect_event(wb);
    start(2'b11);
    wr_stream(1'b1, wb, 1);
    tick(5);
    wr_stream(1'b0, wa, 1);
    wait_done("t2", 300, 1'b1);
    chk("t2_sync_err", 32'(sync_err), 32'd0);

    // Backpressure for 10 cycles mid-event
    rdy_mode = 2;
    tick(2);
    wa = {16'hA021, 16'h0022, 16'h0023, 16'h2024, 16'h4025, 16'hC026};
    expect_event(wa);
    start(2'b01);
    wr_stream(1'b0, wa, 0);
    tick(10);
    @(negedge clk80);
    chk("t3_held_valid", 32'(out_valid), 32'd1);
    chk("t3_held_data", 32'(out_data), 32'hA021);
    rdy_mode = 0;
    wait_done("t3", 300, 1'b1);

    // Garbage before header
    rdy_mode = 1;
    wa = {16'h8031, 16'h0032, 16'hA033, 16'h1034, 16'hC035};
    expect_event(wa);
    start(2'b01);
    wr_stream(1'b0, wa, 0);
    wait_done("t5", 200, 1'b1);
    chk("t5_sync_err", 32'(sync_err), 32'd1);

    // Timeout in DAT_A, then B event
    start(2'b11);
    wr(1'b0, 16'hA0F0);
    expq.push_back(16'hA0F0);
    expq.push_back(16'hDFEE);
    wb = {16'hA1F0, 16'h21F1, 16'hC1F2};
    expect_event(wb);
    wr_stream(1'b1, wb, 0);
    tick(900);
    chk("t6_no_early_tmo", 32'(tmo), 32'd0);
    wait_done("t6", 3000, 1'b1);
    chk("t6_tmo", 32'(tmo), 32'd1);

    // Overflow: 17 writes with no pops
    for (int i = 0; i < 16; i++) wr(1'b0, (i == 0) ? 16'hA200 : 16'(16'h0200 + i));
    chk("t4_ovf_before", 32'(ovf), 32'd0);
    wr(1'b0, 16'hC2FF);
    @(negedge clk80);
    chk("t4_ovf", 32'(ovf), 32'd1);
    for (int i = 0; i < 16; i++) expq.push_back((i == 0) ? 16'hA200 : 16'(16'h0200 + i));
    expq.push_back(16'hC2AA);
    start(2'b01);
    tick(30);
    wr(1'b0, 16'hC2AA);
    wait_done("t4", 300, 1'b1);

    // Randomized rounds with random backpressure
    rdy_mode = 0;
    for (int r = 0; r < 40; r++) begin
      m = 2'($urandom_range(1, 3));
      wa = {};
      wb = {};
      if (m[0]) gen_event(wa, $urandom_range(0, 2));
      if (m[1]) gen_event(wb, $urandom_range(0, 2));
      expect_event(wa);
      expect_event(wb);
      start(m);
      fork
        wr_stream(1'b0, wa, 3);
        wr_stream(1'b1, wb, 3);
      join
      wait_done("rand_round", 2000, 1'b1);
    end

    // Reset mid-event discards state and FIFO contents
    rdy_mode = 1;
    tick(2);
    start(2'b01);
    wa = {16'hA300, 16'h0301, 16'h0302};
    expect_event(wa);
    wr_stream(1'b0, wa, 0);
    wr(1'b1, 16'hA3B0);
    wr(1'b1, 16'h03B1);
    wait_done("rst_drain", 100, 1'b0);
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clk80);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_flags", 32'({ovf, sync_err, tmo}), 32'd0);
    tick(1);
    wa = {16'hA401, 16'h0402, 16'hC403};
    wb = {16'hA411, 16'hC412};
    expect_event(wa);
    expect_event(wb);
    start(2'b11);
    fork
      wr_stream(1'b0, wa, 1);
      wr_stream(1'b1, wb, 1);
    join
    wait_done("after_rst", 300, 1'b1);
    chk("after_rst_sync_err", 32'(sync_err), 32'd0);

    tick(5);
    chk("scoreboard_empty", 32'(expq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
